// File: rtl/fft_frame_packer_pkg.sv
// Shared definitions for the FFT frame packer: sample width, buffer word layout,
// write-FSM encoding and the saturating drop-counter helper.
package fft_frame_packer_pkg;

    localparam int SAMPLE_W = 12;
    localparam int DROP_W   = 16;

    // Flag bits sit directly above the sample in each buffer word: {sop, eop, data}
    localparam int SOP_OFS = 1;
    localparam int EOP_OFS = 0;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_SKIP   = 2'd2
    } wr_state_e;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        if (v == {DROP_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + DROP_W'(1);
        end
    endfunction

endpackage

// File: rtl/fft_frame_packer_if.sv
// Sample sink and Avalon-ST frame source of the packer; master is the packer,
// slave is whatever feeds samples in and drains frames out.
interface fft_frame_packer_if #(
    parameter int DATA_W = 12
);
    logic signed [DATA_W-1:0] in_data;
    logic                     in_valid;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_sop;
    logic                     out_eop;

    modport master (
        input  in_data, in_valid, out_ready,
        output out_data, out_valid, out_sop, out_eop
    );

    modport slave (
        output in_data, in_valid, out_ready,
        input  out_data, out_valid, out_sop, out_eop
    );
endinterface

// File: rtl/fft_frame_packer_sync_fifo_sc.sv
// Single-clock FIFO with an inferred RAM and asynchronous head read, so the
// packer's output register can capture the head word in the cycle after a write.
module fft_frame_packer_sync_fifo_sc #(
    parameter int W     = 14,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_full;
    logic          w_wr_ok;
    logic          w_rd_ok;

    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign empty   = (r_count == {(AW+1){1'b0}});
    assign w_rd_ok = rd_en && !empty;
    assign w_wr_ok = wr_en && (!w_full || w_rd_ok);
    assign rd_data = r_mem[r_rd_ptr];
    assign count   = r_count;

    // Storage array; left unreset so it maps onto RAM
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
        end
    end

    // Occupancy; a simultaneous read and write leaves it unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= {(AW+1){1'b0}};
        end else begin
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fft_frame_packer.sv
// Cuts a non-stallable sample stream into FRAME_LEN-point frames, admitting or
// dropping each frame whole, and replays buffered frames as an Avalon-ST source.
module fft_frame_packer
    import fft_frame_packer_pkg::*;
#(
    parameter int DATA_W    = SAMPLE_W,
    parameter int FRAME_LEN = 1024,
    parameter int DEPTH     = 2048
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    fft_frame_packer_if.master    bus,
    output logic                  frame_drop,
    output logic [DROP_W-1:0]     drop_cnt,
    output logic                  busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int IW = $clog2(FRAME_LEN);
    localparam int W  = DATA_W + 2;

    wr_state_e         r_state;
    wr_state_e         w_state_nxt;
    logic [IW-1:0]     r_idx;
    logic [IW-1:0]     w_idx_nxt;
    logic              w_last;
    logic              w_wr;
    logic              w_wr_sop;
    logic              w_wr_eop;
    logic              w_drop;
    logic              w_rd;
    logic              w_empty;
    logic              w_admit;
    logic [W-1:0]      w_wr_word;
    logic [W-1:0]      w_rd_word;
    logic [AW:0]       w_count;
    logic [AW+1:0]     w_free;
    logic              r_frame_drop;
    logic [DROP_W-1:0] r_drop_cnt;
    logic              r_out_valid;
    logic              r_out_sop;
    logic              r_out_eop;
    logic [DATA_W-1:0] r_out_data;

    // Head register pulls a word when it is empty or its beat is being taken
    assign w_rd      = (!r_out_valid || bus.out_ready) && !w_empty;
    // Free space counts a read in the same cycle as already released
    assign w_free    = (AW+2)'(DEPTH) - {1'b0, w_count} + {{(AW+1){1'b0}}, w_rd};
    assign w_admit   = (w_free >= (AW+2)'(FRAME_LEN));
    assign w_last    = (r_idx == IW'(FRAME_LEN - 1));
    assign w_wr_word = {w_wr_sop, w_wr_eop, bus.in_data};

    fft_frame_packer_sync_fifo_sc #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (w_wr),
        .wr_data (w_wr_word),
        .rd_en   (w_rd),
        .rd_data (w_rd_word),
        .count   (w_count),
        .empty   (w_empty)
    );

    // Write FSM state and point index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_WAIT;
            r_idx   <= {IW{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Write FSM: advances only on valid samples; en is looked at only between frames
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_wr        = 1'b0;
        w_wr_sop    = 1'b0;
        w_wr_eop    = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            ST_WAIT: begin
                if (bus.in_valid && en) begin
                    w_idx_nxt = IW'(1);
                    if (w_admit) begin
                        w_wr        = 1'b1;
                        w_wr_sop    = 1'b1;
                        w_state_nxt = ST_ACCEPT;
                    end else begin
                        w_drop      = 1'b1;
                        w_state_nxt = ST_SKIP;
                    end
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_ACCEPT: begin
                if (bus.in_valid) begin
                    w_wr = 1'b1;
                    if (w_last) begin
                        w_wr_eop    = 1'b1;
                        w_idx_nxt   = {IW{1'b0}};
                        w_state_nxt = ST_WAIT;
                    end else begin
                        w_idx_nxt = r_idx + IW'(1);
                    end
                end else begin
                    w_state_nxt = ST_ACCEPT;
                end
            end
            ST_SKIP: begin
                if (bus.in_valid) begin
                    if (w_last) begin
                        w_idx_nxt   = {IW{1'b0}};
                        w_state_nxt = ST_WAIT;
                    end else begin
                        w_idx_nxt = r_idx + IW'(1);
                    end
                end else begin
                    w_state_nxt = ST_SKIP;
                end
            end
            default: begin
                w_state_nxt = ST_WAIT;
                w_idx_nxt   = {IW{1'b0}};
            end
        endcase
    end

    // Drop pulse and saturating drop counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_drop <= 1'b0;
            r_drop_cnt   <= {DROP_W{1'b0}};
        end else begin
            r_frame_drop <= w_drop;
            if (w_drop) begin
                r_drop_cnt <= sat_inc(r_drop_cnt);
            end else begin
                r_drop_cnt <= r_drop_cnt;
            end
        end
    end

    // Output head register; holds its beat while the FFT stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
            r_out_data  <= {DATA_W{1'b0}};
        end else if (w_rd) begin
            r_out_valid <= 1'b1;
            r_out_sop   <= w_rd_word[DATA_W + SOP_OFS];
            r_out_eop   <= w_rd_word[DATA_W + EOP_OFS];
            r_out_data  <= w_rd_word[DATA_W-1:0];
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_sop   = r_out_sop;
    assign bus.out_eop   = r_out_eop;
    assign bus.out_data  = r_out_data;
    assign frame_drop    = r_frame_drop;
    assign drop_cnt      = r_drop_cnt;
    assign busy          = (w_count != {(AW+1){1'b0}}) || r_out_valid || (r_state == ST_ACCEPT);

endmodule

// File: tb/tb_fft_frame_packer.sv
// Directed-plus-random bench for fft_frame_packer: a queue-based frame/buffer model
// predicts every output beat, drop pulse, drop count and busy flag cycle by cycle.
module tb_fft_frame_packer;
    localparam int DW = 12;
    localparam int FL = 8;
    localparam int DP = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        frame_drop;
    logic [15:0] drop_cnt;
    logic        busy;

    fft_frame_packer_if #(.DATA_W(DW)) bus ();

    fft_frame_packer #(.DATA_W(DW), .FRAME_LEN(FL), .DEPTH(DP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .bus        (bus),
        .frame_drop (frame_drop),
        .drop_cnt   (drop_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: beats are {sop, eop, data}
    logic [13:0] m_q[$];
    logic [13:0] m_sb[$];
    logic [13:0] m_slot;
    bit          m_slot_v;
    int          m_pos;
    bit          m_accepting;
    int          m_drops;
    bit          m_drop_pulse;
    bit          m_busy;
    bit          prev_stall;
    logic [13:0] prev_beat;
    logic [13:0] got[$];
    logic [11:0] sent[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] dut_beat();
        return {bus.out_sop, bus.out_eop, bus.out_data};
    endfunction

    task automatic m_reset();
        m_q.delete();
        m_sb.delete();
        m_slot       = 14'd0;
        m_slot_v     = 1'b0;
        m_pos        = 0;
        m_accepting  = 1'b0;
        m_drops      = 0;
        m_drop_pulse = 1'b0;
        m_busy       = 1'b0;
        prev_stall   = 1'b0;
        prev_beat    = 14'd0;
    endtask

    task automatic model_step(input bit v, input logic [11:0] d, input bit e, input bit r);
        bit          rd;
        bit          hs;
        bit          wr;
        int          free;
        logic [13:0] w;
        rd   = (!m_slot_v || r) && (m_q.size() > 0);
        hs   = m_slot_v && r;
        free = DP - m_q.size() + (rd ? 1 : 0);
        wr   = 1'b0;
        w    = 14'd0;
        m_drop_pulse = 1'b0;
        if (v) begin
            if (m_pos == 0) begin
                if (e) begin
                    if (free >= FL) begin
                        wr = 1'b1;
                        w  = {2'b10, d};
                        m_accepting = 1'b1;
                    end else begin
                        m_accepting  = 1'b0;
                        m_drop_pulse = 1'b1;
                        if (m_drops < 65535) m_drops++;
                    end
                    m_pos = 1;
                end
            end else begin
                if (m_accepting) begin
                    wr = 1'b1;
                    w  = {1'b0, (m_pos == FL - 1), d};
                end
                m_pos = (m_pos == FL - 1) ? 0 : m_pos + 1;
            end
        end
        if (rd) begin
            m_slot   = m_q.pop_front();
            m_slot_v = 1'b1;
        end else if (hs) begin
            m_slot_v = 1'b0;
        end
        if (wr) begin
            m_q.push_back(w);
            m_sb.push_back(w);
        end
        m_busy = (m_q.size() != 0) || m_slot_v || (m_pos != 0 && m_accepting);
    endtask

    task automatic step(input bit v, input logic [11:0] d, input bit e, input bit r);
        logic [13:0] cur;
        logic [13:0] expb;
        bus.in_valid  = v;
        bus.in_data   = d;
        en            = e;
        bus.out_ready = r;
        cur = dut_beat();
        if (prev_stall) chk("stall_hold", 32'(cur), 32'(prev_beat));
        prev_stall = bus.out_valid && !r;
        prev_beat  = cur;
        if (bus.out_valid && r) begin
            got.push_back(cur);
            if (m_sb.size() == 0) begin
                chk("beat_expected", 32'(m_sb.size()), 32'd1);
            end else begin
                expb = m_sb.pop_front();
                chk("hs_beat", 32'(cur), 32'(expb));
            end
        end
        @(posedge clk);
        model_step(v, d, e, r);
        #1;
        chk("out_valid", 32'(bus.out_valid), 32'(m_slot_v));
        if (m_slot_v) chk("out_beat", 32'(dut_beat()), 32'(m_slot));
        chk("frame_drop", 32'(frame_drop), 32'(m_drop_pulse));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drops));
        chk("busy", 32'(busy), 32'(m_busy));
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 12'd0, 1'b1, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    initial begin
        int base;
        logic [11:0] rv;
        bus.in_valid  = 1'b0;
        bus.in_data   = 12'd0;
        bus.out_ready = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        // 1: ramp 0..23, free-flowing output
        got.delete();
        for (int i = 0; i < 24; i++) begin
            step(1'b1, 12'(i), 1'b1, 1'b1);
            if (i == 0) chk("t1_lat_cycle1", 32'(bus.out_valid), 32'd0);
            if (i == 1) chk("t1_first_beat", 32'({bus.out_valid, dut_beat()}), 32'({1'b1, 14'h2000}));
        end
        drain(4);
        chk("t1_count", 32'(got.size()), 32'd24);
        for (int i = 0; i < got.size(); i++)
            chk("t1_beat", 32'(got[i]), 32'({(i % FL == 0), (i % FL == FL - 1), 12'(i)}));

        // 2: output stalled, ramp 0..31: two frames fit, two dropped
        got.delete();
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 12'(i), 1'b1, 1'b0);
            if (i == 16) chk("t2_drop_at16", 32'({frame_drop, drop_cnt}), 32'({1'b1, 16'd1}));
            if (i == 24) chk("t2_drop_at24", 32'({frame_drop, drop_cnt}), 32'({1'b1, 16'd2}));
        end
        drain(20);
        chk("t2_count", 32'(got.size()), 32'd16);
        for (int i = 0; i < got.size(); i++) chk("t2_data", 32'(got[i][11:0]), 32'(i));

        // 3: random data, out_ready toggling, sustained input
        got.delete();
        base = drop_cnt;
        for (int i = 0; i < 48; i++) begin
            rv = 12'($urandom);
            step(1'b1, rv, 1'b1, (i % 2 == 0));
        end
        drain(24);
        chk("t3_dropped_some", 32'(drop_cnt > 16'(base)), 32'd1);
        chk("t3_all_delivered", 32'(m_sb.size()), 32'd0);

        // 4: en falls after the third sample of a frame
        got.delete();
        for (int i = 0; i < 16; i++) step(1'b1, 12'(200 + i), (i < 3), 1'b1);
        drain(6);
        chk("t4_count", 32'(got.size()), 32'd8);
        if (got.size() == 8) begin
            chk("t4_first", 32'(got[0]), 32'({2'b10, 12'd200}));
            chk("t4_last", 32'(got[7]), 32'({2'b01, 12'd207}));
        end
        chk("t4_busy_idle", 32'(busy), 32'd0);

        // 5: asynchronous reset mid-frame
        got.delete();
        for (int i = 0; i < 5; i++) step(1'b1, 12'(50 + i), 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_beat", 32'({bus.out_valid, dut_beat()}), 32'd0);
        chk("t5_rst_misc", 32'({frame_drop, drop_cnt, busy}), 32'd0);
        m_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b1, 12'(300 + i), 1'b1, 1'b1);
        drain(4);
        chk("t5_count", 32'(got.size()), 32'd8);
        if (got.size() > 0) chk("t5_first", 32'(got[0]), 32'({2'b10, 12'd300}));

        // 6: in_valid one cycle in three, random data
        got.delete();
        sent.delete();
        for (int i = 0; i < 72; i++) begin
            rv = 12'($urandom);
            if (i % 3 == 0) sent.push_back(rv);
            step((i % 3 == 0), rv, 1'b1, 1'b1);
        end
        drain(4);
        chk("t6_count", 32'(got.size()), 32'd24);
        for (int i = 0; i < got.size(); i++)
            chk("t6_beat", 32'(got[i]), 32'({(i % FL == 0), (i % FL == FL - 1), sent[i]}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
